// File: rtl/dcache_mem_arbiter.sv
// Round-robin arbiter that shares NUM_CHANNELS memory channels among the dcache miss/writeback
// requesters. Each channel runs its own request/response FSM and relays results to its owner.
module dcache_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    // state       | meaning
    // S_IDLE      | channel free, may be granted this edge
    // S_READ_WAIT | mem_read_valid high, waiting for mem_read_ready
    // S_WRITE_WAIT| mem_write_valid high, waiting for mem_write_ready
    // S_*_RELAY   | owner's ready high until its matching valid drops
    typedef enum logic [2:0] {
        S_IDLE, S_READ_WAIT, S_WRITE_WAIT, S_READ_RELAY, S_WRITE_RELAY
    } state_t;

    state_t               state_q [NUM_CHANNELS];
    idx_t                 owner_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0] rdata_q [NUM_CHANNELS];
    idx_t                 rr_ptr_q, rr_ptr_d;
    logic [NUM_CONSUMERS-1:0] busy_q, busy_d;

    logic [NUM_CHANNELS-1:0]  grant_vld;
    logic [NUM_CHANNELS-1:0]  grant_wr;
    idx_t                     grant_idx [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    idx_t                     cand;

    function automatic idx_t wrap_add(input idx_t base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CONSUMERS) s = s - NUM_CONSUMERS;
        return idx_t'(s);
    endfunction

    // Channels are visited in ascending order so lower channels win ties within one edge.
    always_comb begin
        taken    = '0;
        found    = 1'b0;
        cand     = '0;
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        grant_vld = '0;
        grant_wr  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant_idx[c] = '0;
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] == S_READ_RELAY && !consumer_read_valid[owner_q[c]])
                busy_d[owner_q[c]] = 1'b0;
            if (state_q[c] == S_WRITE_RELAY && !consumer_write_valid[owner_q[c]])
                busy_d[owner_q[c]] = 1'b0;
            if (state_q[c] == S_IDLE) begin
                found = 1'b0;
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    cand = wrap_add(rr_ptr_q, k);
                    if (!found && (consumer_read_valid[cand] || consumer_write_valid[cand])
                        && !busy_q[cand] && !taken[cand]) begin
                        found        = 1'b1;
                        grant_vld[c] = 1'b1;
                        grant_idx[c] = cand;
                        grant_wr[c]  = !consumer_read_valid[cand];
                        taken[cand]  = 1'b1;
                        rr_ptr_d     = wrap_add(cand, 1);
                    end
                end
            end
        end
        busy_d = busy_d | taken;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            busy_q   <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= S_IDLE;
                owner_q[c] <= '0;
                addr_q[c]  <= '0;
                wdata_q[c] <= '0;
                rdata_q[c] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state_q[c])
                    S_IDLE: begin
                        if (grant_vld[c]) begin
                            owner_q[c] <= grant_idx[c];
                            if (grant_wr[c]) begin
                                state_q[c] <= S_WRITE_WAIT;
                                addr_q[c]  <= consumer_write_address[grant_idx[c]];
                                wdata_q[c] <= consumer_write_data[grant_idx[c]];
                            end else begin
                                state_q[c] <= S_READ_WAIT;
                                addr_q[c]  <= consumer_read_address[grant_idx[c]];
                            end
                        end
                    end
                    S_READ_WAIT: begin
                        if (mem_read_ready[c]) begin
                            rdata_q[c] <= mem_read_data[c];
                            state_q[c] <= S_READ_RELAY;
                        end
                    end
                    S_WRITE_WAIT: begin
                        if (mem_write_ready[c]) state_q[c] <= S_WRITE_RELAY;
                    end
                    S_READ_RELAY: begin
                        if (!consumer_read_valid[owner_q[c]]) state_q[c] <= S_IDLE;
                    end
                    S_WRITE_RELAY: begin
                        if (!consumer_write_valid[owner_q[c]]) state_q[c] <= S_IDLE;
                    end
                    default: state_q[c] <= S_IDLE;
                endcase
            end
        end
    end

    // Outputs decode straight from channel registers, so reset clears them without a clock.
    always_comb begin
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        mem_read_valid       = '0;
        mem_read_address     = '0;
        mem_write_valid      = '0;
        mem_write_address    = '0;
        mem_write_data       = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] == S_READ_WAIT) begin
                mem_read_valid[c]   = 1'b1;
                mem_read_address[c] = addr_q[c];
            end
            if (state_q[c] == S_WRITE_WAIT) begin
                mem_write_valid[c]   = 1'b1;
                mem_write_address[c] = addr_q[c];
                mem_write_data[c]    = wdata_q[c];
            end
            if (state_q[c] == S_READ_RELAY) begin
                consumer_read_ready[owner_q[c]] = 1'b1;
                consumer_read_data[owner_q[c]]  = rdata_q[c];
            end
            if (state_q[c] == S_WRITE_RELAY) begin
                consumer_write_ready[owner_q[c]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Scoreboard bench for dcache_mem_arbiter: a 4-channel instance for most scenarios and a
// 1-channel instance for round-robin fairness, both fed by a latency-programmable memory model.
module tb_dcache_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]      rv = '0, wv = '0;
    logic [7:0][7:0] ra = '0, wa = '0, wd = '0;
    logic [7:0]      crr, cwr;
    logic [7:0][7:0] crd;
    logic [3:0]      mrv, mwv;
    logic [3:0][7:0] mra, mwa, mwd;
    logic [3:0]      mrr = '0, mwr = '0;
    logic [3:0][7:0] mrd = '0;

    logic [7:0]      f_rv = '0, f_wv = '0;
    logic [7:0][7:0] f_ra = '0, f_wa = '0, f_wd = '0;
    logic [7:0]      f_crr, f_cwr;
    logic [7:0][7:0] f_crd;
    logic [0:0]      f_mrv, f_mwv;
    logic [0:0][7:0] f_mra, f_mwa, f_mwd;
    logic [0:0]      f_mrr = '0, f_mwr = '0;
    logic [0:0][7:0] f_mrd = '0;

    dcache_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd),
        .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
        .mem_write_ready(mwr)
    );

    dcache_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(f_rv), .consumer_read_address(f_ra),
        .consumer_read_ready(f_crr), .consumer_read_data(f_crd),
        .consumer_write_valid(f_wv), .consumer_write_address(f_wa), .consumer_write_data(f_wd),
        .consumer_write_ready(f_cwr),
        .mem_read_valid(f_mrv), .mem_read_address(f_mra),
        .mem_read_ready(f_mrr), .mem_read_data(f_mrd),
        .mem_write_valid(f_mwv), .mem_write_address(f_mwa), .mem_write_data(f_mwd),
        .mem_write_ready(f_mwr)
    );

    // Memory model: ready pulses mem_lat cycles after valid is seen; read data = address ^ 0x99.
    int mem_lat = 1;
    bit mem_en  = 1'b1;
    int rcnt [4];
    int wcnt [4];
    int frcnt = 0;

    initial begin
        for (int c = 0; c < 4; c++) begin rcnt[c] = 0; wcnt[c] = 0; end
        forever begin
            @(negedge clk);
            if (mem_en) begin
                for (int c = 0; c < 4; c++) begin
                    if (mrr[c]) mrr[c] = 1'b0;
                    else if (mrv[c]) begin
                        rcnt[c]++;
                        if (rcnt[c] >= mem_lat) begin
                            mrr[c] = 1'b1; mrd[c] = mra[c] ^ 8'h99; rcnt[c] = 0;
                        end
                    end else rcnt[c] = 0;
                    if (mwr[c]) mwr[c] = 1'b0;
                    else if (mwv[c]) begin
                        wcnt[c]++;
                        if (wcnt[c] >= mem_lat) begin mwr[c] = 1'b1; wcnt[c] = 0; end
                    end else wcnt[c] = 0;
                end
                if (f_mrr[0]) f_mrr[0] = 1'b0;
                else if (f_mrv[0]) begin
                    frcnt++;
                    if (frcnt >= mem_lat) begin
                        f_mrr[0] = 1'b1; f_mrd[0] = f_mra[0] ^ 8'h99; frcnt = 0;
                    end
                end else frcnt = 0;
            end
        end
    end

    task automatic do_reset;
        rv = '0; wv = '0; f_rv = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        mem_en = 1'b0;
        reset  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            rv = 8'($urandom); wv = 8'($urandom);
            ra = {$urandom, $urandom}; wa = {$urandom, $urandom}; wd = {$urandom, $urandom};
            mrr = 4'($urandom); mwr = 4'($urandom); mrd = $urandom;
            f_rv = 8'($urandom); f_ra = {$urandom, $urandom}; f_mrr = 1'($urandom);
        end
        @(negedge clk);
        n_checks++;
        if ({crr, crd, cwr, mrv, mra, mwv, mwa, mwd} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got crr=%h cwr=%h mrv=%h mwv=%h mra=%h, required all 0",
                     crr, cwr, mrv, mwv, mra);
        end
        n_checks++;
        if ({f_crr, f_crd, f_cwr, f_mrv, f_mra, f_mwv, f_mwa, f_mwd} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_1ch: got crr=%h mrv=%h, required all 0", f_crr, f_mrv);
        end
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0; f_rv = '0; f_ra = '0;
        mrr = '0; mwr = '0; mrd = '0; f_mrr = '0; f_mrd = '0;
        mem_en = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({crr, crd, cwr, mrv, mra, mwv, mwa, mwd} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got crr=%h cwr=%h mrv=%h mwv=%h, required all 0",
                     crr, cwr, mrv, mwv);
        end
    endtask

    task automatic test_single_read;
        logic [7:0] exp_q [$];
        int cyc;
        do_reset();
        mem_lat = 3;
        rv[3] = 1'b1; ra[3] = 8'h5A;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        n_checks++;
        if (mrv !== 4'b0001 || mra[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_grant: got mrv=%b addr=%h, required 0001 / 5a", mrv, mra[0]);
        end
        cyc = 0;
        while (!crr[3] && cyc < 20) begin @(negedge clk); cyc++; end
        n_checks++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles, required 3", cyc);
        end
        n_checks++;
        if (crr !== 8'b0000_1000 || crd[3] !== exp_q.pop_front()) begin
            n_fail++;
            $display("FAIL single_data: got ready=%b data=%h, required 00001000 / c3", crr, crd[3]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (crr[3] !== 1'b1 || crd[3] !== 8'hC3 || mrv !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_hold: got ready=%b data=%h mrv=%b, required 1 / c3 / 0000",
                     crr[3], crd[3], mrv);
        end
        rv[3] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (crr !== 8'h00 || crd !== '0) begin
            n_fail++;
            $display("FAIL single_release: got ready=%b data=%h, required 0 / 0", crr, crd);
        end
        rv[3] = 1'b1; ra[3] = 8'h5B;
        @(negedge clk);
        n_checks++;
        if (mrv !== 4'b0001 || mra[0] !== 8'h5B) begin
            n_fail++;
            $display("FAIL single_regrant: got mrv=%b addr=%h, required 0001 / 5b", mrv, mra[0]);
        end
        rv[3] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct { int idx; logic [7:0] data; } rd_exp_t;

    task automatic test_contention;
        rd_exp_t    data_q [$];
        logic [7:0] gaddr_q [$];
        rd_exp_t    e;
        logic [7:0] ga;
        logic [3:0] prev;
        int recv [8];
        int total, cyc;
        do_reset();
        mem_lat = 2;
        for (int i = 0; i < 8; i++) begin
            rv[i] = 1'b1;
            ra[i] = 8'h20 + 8'(i * 3);
            e.idx = i; e.data = ra[i] ^ 8'h99;
            data_q.push_back(e);
            gaddr_q.push_back(ra[i]);
            recv[i] = 0;
        end
        prev = '0; total = 0; cyc = 0;
        while (total < 8 && cyc < 60) begin
            @(negedge clk); cyc++;
            for (int c = 0; c < 4; c++) begin
                if (mrv[c] && !prev[c]) begin
                    ga = (gaddr_q.size() > 0) ? gaddr_q.pop_front() : 8'hxx;
                    n_checks++;
                    if (mra[c] !== ga) begin
                        n_fail++;
                        $display("FAIL contention_grant ch%0d: got addr=%h, required %h", c, mra[c], ga);
                    end
                end
            end
            prev = mrv;
            for (int i = 0; i < 8; i++) begin
                if (rv[i] && crr[i]) begin
                    if (data_q.size() > 0) e = data_q.pop_front();
                    else begin e.idx = -1; e.data = 8'hxx; end
                    n_checks++;
                    if (e.idx !== i || crd[i] !== e.data) begin
                        n_fail++;
                        $display("FAIL contention_data: got consumer %0d data=%h, required consumer %0d data=%h",
                                 i, crd[i], e.idx, e.data);
                    end
                    recv[i]++; total++; rv[i] = 1'b0;
                end
            end
        end
        n_checks++;
        if (total !== 8) begin
            n_fail++;
            $display("FAIL contention_timeout: got %0d responses, required 8", total);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (recv[i] !== 1) begin
                n_fail++;
                $display("FAIL contention_once c%0d: got %0d responses, required 1", i, recv[i]);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_fairness;
        int gq [$];
        int ngr, cyc, exp_c, i;
        logic prev;
        do_reset();
        mem_lat = 1;
        f_ra[0] = 8'h40; f_ra[5] = 8'h45;
        f_rv[0] = 1'b1;  f_rv[5] = 1'b1;
        gq.push_back(0); gq.push_back(5); gq.push_back(0); gq.push_back(5);
        ngr = 0; cyc = 0; prev = 1'b0;
        while (ngr < 4 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (f_mrv[0] && !prev) begin
                exp_c = (gq.size() > 0) ? gq.pop_front() : -1;
                n_checks++;
                if (f_mra[0] !== 8'h40 + 8'(exp_c)) begin
                    n_fail++;
                    $display("FAIL fairness_order grant %0d: got addr=%h, required consumer %0d",
                             ngr, f_mra[0], exp_c);
                end
                ngr++;
            end
            prev = f_mrv[0];
            for (int j = 0; j < 2; j++) begin
                i = j * 5;
                if (f_rv[i] && f_crr[i]) begin
                    n_checks++;
                    if (f_crd[i] !== (f_ra[i] ^ 8'h99)) begin
                        n_fail++;
                        $display("FAIL fairness_data c%0d: got %h, required %h", i, f_crd[i], f_ra[i] ^ 8'h99);
                    end
                    f_rv[i] = 1'b0;
                end else if (!f_rv[i] && !f_crr[i]) f_rv[i] = 1'b1;
            end
        end
        n_checks++;
        if (ngr !== 4) begin
            n_fail++;
            $display("FAIL fairness_timeout: got %0d grants, required 4", ngr);
        end
        f_rv = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_read_write;
        int ev_q [$];
        int cyc, ev;
        bit rd_done;
        logic [3:0] prev_w;
        do_reset();
        mem_lat = 1;
        rv[2] = 1'b1; ra[2] = 8'h31;
        wv[2] = 1'b1; wa[2] = 8'h10; wd[2] = 8'h77;
        ev_q.push_back(0); ev_q.push_back(1);
        rd_done = 1'b0; prev_w = '0; cyc = 0;
        @(negedge clk);
        n_checks++;
        if (mrv !== 4'b0001 || mwv !== 4'b0000) begin
            n_fail++;
            $display("FAIL rw_read_first: got mrv=%b mwv=%b, required 0001 / 0000", mrv, mwv);
        end
        while ((rv[2] || wv[2]) && cyc < 40) begin
            @(negedge clk); cyc++;
            if (mwv !== 4'b0000 && prev_w === 4'b0000) begin
                n_checks++;
                if (!rd_done || mwv !== 4'b0001 || mwa[0] !== 8'h10 || mwd[0] !== 8'h77) begin
                    n_fail++;
                    $display("FAIL rw_write_req: got rd_done=%0d mwv=%b addr=%h data=%h, required 1 / 0001 / 10 / 77",
                             rd_done, mwv, mwa[0], mwd[0]);
                end
            end
            prev_w = mwv;
            if (rv[2] && crr[2]) begin
                ev = (ev_q.size() > 0) ? ev_q.pop_front() : -1;
                n_checks++;
                if (ev !== 0 || crd[2] !== 8'hA8) begin
                    n_fail++;
                    $display("FAIL rw_read_done: got event=%0d data=%h, required 0 / a8", ev, crd[2]);
                end
                rd_done = 1'b1; rv[2] = 1'b0;
            end
            if (wv[2] && cwr[2]) begin
                ev = (ev_q.size() > 0) ? ev_q.pop_front() : -1;
                n_checks++;
                if (ev !== 1 || cwr !== 8'b0000_0100) begin
                    n_fail++;
                    $display("FAIL rw_write_done: got event=%0d wready=%b, required 1 / 00000100", ev, cwr);
                end
                wv[2] = 1'b0;
            end
        end
        n_checks++;
        if (rv[2] || wv[2] || ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL rw_timeout: got rv=%b wv=%b pending=%0d, required 0 / 0 / 0", rv[2], wv[2], ev_q.size());
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (cwr !== 8'h00 || mwv !== 4'b0000) begin
            n_fail++;
            $display("FAIL rw_release: got wready=%b mwv=%b, required 0 / 0", cwr, mwv);
        end
    endtask

    task automatic test_mid_reset;
        do_reset();
        mem_lat = 20;
        rv[6] = 1'b1; ra[6] = 8'h66;
        @(negedge clk);
        n_checks++;
        if (mrv !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_grant: got mrv=%b, required 0001", mrv);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (mrv !== 4'b0000 || mra !== '0) begin
            n_fail++;
            $display("FAIL midrst_async_drop: got mrv=%b addr=%h, required 0000 / 0", mrv, mra);
        end
        rv[6] = 1'b0;
        @(negedge clk);
        reset = 1'b1; mem_lat = 1;
        rv[1] = 1'b1; ra[1] = 8'h11;
        @(negedge clk);
        n_checks++;
        if (mrv !== 4'b0001 || mra[0] !== 8'h11) begin
            n_fail++;
            $display("FAIL midrst_fresh_grant: got mrv=%b addr=%h, required 0001 / 11", mrv, mra[0]);
        end
        @(negedge clk);
        n_checks++;
        if (crr !== 8'b0000_0010 || crd[1] !== 8'h88) begin
            n_fail++;
            $display("FAIL midrst_zero_wait: got ready=%b data=%h, required 00000010 / 88", crr, crd[1]);
        end
        rv[1] = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (crr !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_release: got ready=%b, required 0", crr);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_read_write();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
